dtfag_idx_seq: RTL and testbench
================================

# dtfag_idx_seq

Index sequencer driving the twiddle-factor address generator of the R16 65536-point FFT. After a start command it produces the (i, t, j) digit tuples in a fixed order, under a valid/ready handshake. It drives the active-low ROM chip enable for each accepted tuple, and signals completion with a one-cycle done pulse. It sits between the stage controller (start/done side) and the address generator/ROM (tuple side).

## Interface
- RADIX_W, 4: width of each digit (matches `radix_width`).
- I_MAX, 15: last value of the outer digit i.
- T_MAX, 15: last value of the middle digit t.
- J_MAX, 15: last value of the inner digit j.
- clk  input  1  rising-edge clock; single clock domain.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a sweep; honoured only in IDLE.
- out_ready  input  1  downstream accepts the current tuple.
- out_valid  output  1  tuple on dtfag_i/t/j is valid.
- dtfag_i  output  RADIX_W  outer digit.
- dtfag_t  output  RADIX_W  middle digit.
- dtfag_j  output  RADIX_W  inner digit.
- rom_cen  output  1  ROM chip enable, active low.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse after the last tuple is accepted.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN: start=1 sampled at a clock edge. Counters load i=0, t=0, j=J_START.
  - J_START is 0, or 1 when the skip-zero feature is compiled in.
- RUN: out_valid=1, busy=1.
- Fire = out_valid & out_ready.
- On fire, the counters advance in this order:
  - j increments first.
  - When j==J_MAX: j wraps to J_START and t increments.
  - When t==T_MAX: t wraps to 0 and i increments.
- RUN → DONE: a fire on the tuple (I_MAX, T_MAX, J_MAX).
- DONE → IDLE unconditionally after one cycle; done=1 only in DONE.
- start is ignored in RUN and DONE; there is no queuing.
- rom_cen = ~fire. This is combinational, so the ROM samples the address in the same cycle as the handshake.
- Without a fire, the tuple is held stable and out_valid is never withdrawn.
- Counters are unsigned RADIX_W bits. Wrap is by compare to the MAX value, not by natural overflow. MAX values must be < 2^RADIX_W.
- Reset values: out_valid=0, busy=0, done=0, rom_cen=1, dtfag_i/t/j=0, state=IDLE.
- Reset asserted mid-sweep aborts the sweep immediately. No done is produced.
- Outside RUN, dtfag_i/t/j hold their last values. Downstream must qualify them with out_valid.

## Timing
- Start latency: start high at edge N gives out_valid=1 with the first tuple during cycle N+1.
- Throughput: one tuple per cycle while out_ready=1.
- Done latency: last fire at edge M gives done=1 during cycle M+1. busy and out_valid are 0 in that same cycle.
- A start in the DONE cycle is dropped. The earliest accepted start is in the first IDLE cycle.
- Sweep length: (I_MAX+1)(T_MAX+1)(J_MAX+1−J_START) fires. The default is 4096.

## Configuration
- DTFAG_SEQ_SKIP_ZERO_EN defined:
  - J_START=1; j runs 1..J_MAX, skipping the trivial unit twiddle (j=0).
  - The default sweep is 3840 fires.
  - The first tuple is (0,0,1), and the tuple after (0,0,15) is (0,1,1).
- Undefined: J_START=0; j runs 0..J_MAX with a 4096-fire default sweep.

## Structure
- Shared package dtfag_pkg holds:
  - RADIX_W default.
  - The FSM state enum (IDLE, RUN, DONE).
  - The J_START constant selected by DTFAG_SEQ_SKIP_ZERO_EN.
- Sub-module dtfag_digit_cnt: one wrap counter instantiated three times.
  - Ports: clk, rst, load, load_val, inc, max.
  - Outputs: value, wrap (asserted combinationally when inc & value==max).
  - The j wrap feeds the t inc; the t wrap feeds the i inc.
  - The FSM detects the last tuple as fire & i-wrap-condition.

## Test plan
- Full sweep, out_ready=1, defaults. Start pulsed at cycle 0 → fires in cycles 1..4096 in order (0,0,0),(0,0,1)…(0,0,15),(0,1,0)…(15,15,15); done=1 in cycle 4097 only; rom_cen=0 in exactly 4096 cycles.
- Backpressure: out_ready=0 for 3 cycles while (0,0,5) is presented → tuple held, out_valid=1, rom_cen=1 during the stall; the next fire delivers (0,0,5) then (0,0,6). There is no skip and no duplicate.
- Start during RUN at tuple (2,3,4) → ignored; the sweep completes with 4096 fires and exactly one done.
- rst pulsed while presenting (1,7,9) → same cycle: out_valid=0, busy=0, rom_cen=1, digits=0; no done follows. A subsequent start restarts from (0,0,0).
- Small parameters I_MAX=1, T_MAX=0, J_MAX=2 with random out_ready → exactly 6 fires: (0,0,0),(0,0,1),(0,0,2),(1,0,0),(1,0,1),(1,0,2), then one done pulse.
- DTFAG_SEQ_SKIP_ZERO_EN defined, defaults → first tuple (0,0,1), (0,0,15) followed by (0,1,1), 3840 fires, no tuple with j=0.

Source files
------------

// File: rtl/dtfag_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dtfag_pkg
// Brief    : Shared constants and FSM state type for the twiddle index sequencer.
//            DTFAG_SEQ_SKIP_ZERO_EN selects whether the inner digit starts at 1.
// Revision : 1.0
// ============================================================================
package dtfag_pkg;

    localparam int DTFAG_RADIX_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

`ifdef DTFAG_SEQ_SKIP_ZERO_EN
    // j=0 addresses the unit twiddle, which the datapath handles trivially
    localparam int J_START = 1;
`else
    localparam int J_START = 0;
`endif

endpackage
`default_nettype wire

// File: rtl/dtfag_digit_cnt.sv
`default_nettype none
// ============================================================================
// Module   : dtfag_digit_cnt
// Brief    : Single index digit counter that restarts at load_val after max.
// Revision : 1.0
// ============================================================================
module dtfag_digit_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    input  logic [W-1:0] max,
    output logic [W-1:0] value,
    output logic         wrap
);

    logic [W-1:0] r_value_q;
    logic [W-1:0] w_value_d;

    always_comb begin
        wrap      = inc & (r_value_q == max);
        w_value_d = r_value_q;
        if (load || wrap) begin
            w_value_d = load_val;
        end else if (inc) begin
            w_value_d = r_value_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_value_q <= '0;
        end else begin
            r_value_q <= w_value_d;
        end
    end

    assign value = r_value_q;

endmodule
`default_nettype wire

// File: rtl/dtfag_idx_seq.sv
`default_nettype none
// ============================================================================
// Module   : dtfag_idx_seq
// Brief    : Emits (i,t,j) twiddle digit tuples under valid/ready after start,
//            with combinational ROM enable and a done pulse.
//            Build option: DTFAG_SEQ_SKIP_ZERO_EN (inner digit runs 1..J_MAX).
// Revision : 1.0
// ============================================================================
module dtfag_idx_seq
    import dtfag_pkg::*;
#(
    parameter int RADIX_W = dtfag_pkg::DTFAG_RADIX_W,
    parameter int I_MAX   = 15,
    parameter int T_MAX   = 15,
    parameter int J_MAX   = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [RADIX_W-1:0] dtfag_i,
    output logic [RADIX_W-1:0] dtfag_t,
    output logic [RADIX_W-1:0] dtfag_j,
    output logic               rom_cen,
    output logic               busy,
    output logic               done
);

    localparam logic [RADIX_W-1:0] C_I_MAX   = RADIX_W'(I_MAX);
    localparam logic [RADIX_W-1:0] C_T_MAX   = RADIX_W'(T_MAX);
    localparam logic [RADIX_W-1:0] C_J_MAX   = RADIX_W'(J_MAX);
    localparam logic [RADIX_W-1:0] C_J_START = RADIX_W'(J_START);
    localparam logic [RADIX_W-1:0] C_ZERO    = '0;

    state_e r_state_q;
    state_e w_state_d;
    logic   w_fire;
    logic   w_load;
    logic   w_j_wrap;
    logic   w_t_wrap;
    logic   w_i_wrap;

    assign w_fire  = out_valid & out_ready;
    assign w_load  = (r_state_q == ST_IDLE) & start;
    // ROM must see the enable in the handshake cycle itself
    assign rom_cen = ~w_fire;

    dtfag_digit_cnt #(.W(RADIX_W)) u_cnt_j (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .load_val (C_J_START),
        .inc      (w_fire),
        .max      (C_J_MAX),
        .value    (dtfag_j),
        .wrap     (w_j_wrap)
    );

    dtfag_digit_cnt #(.W(RADIX_W)) u_cnt_t (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .load_val (C_ZERO),
        .inc      (w_j_wrap),
        .max      (C_T_MAX),
        .value    (dtfag_t),
        .wrap     (w_t_wrap)
    );

    dtfag_digit_cnt #(.W(RADIX_W)) u_cnt_i (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .load_val (C_ZERO),
        .inc      (w_t_wrap),
        .max      (C_I_MAX),
        .value    (dtfag_i),
        .wrap     (w_i_wrap)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= ST_IDLE;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            ST_IDLE: if (start) w_state_d = ST_RUN;
            // outer digit wrapping on a fire means the final tuple was taken
            ST_RUN:  if (w_fire && w_i_wrap) w_state_d = ST_DONE;
            ST_DONE: w_state_d = ST_IDLE;
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        out_valid = (r_state_q == ST_RUN);
        busy      = (r_state_q == ST_RUN);
        done      = (r_state_q == ST_DONE);
    end

endmodule
`default_nettype wire

// File: tb/tb_dtfag_idx_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_dtfag_idx_seq
// Brief    : Scoreboard bench for dtfag_idx_seq (default and small instances).
// Revision : 1.0
// ============================================================================
module tb_dtfag_idx_seq;

    localparam int W = 4;
`ifdef DTFAG_SEQ_SKIP_ZERO_EN
    localparam int J0 = 1;
`else
    localparam int J0 = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic out_ready = 1'b0;
    logic s_start = 1'b0;
    logic s_ready = 1'b0;

    logic         out_valid, rom_cen, busy, done;
    logic [W-1:0] di, dt, dj;
    logic         s_valid, s_rom_cen, s_busy, s_done;
    logic [W-1:0] s_di, s_dt, s_dj;

    always #5 clk = ~clk;

    dtfag_idx_seq dut (
        .clk(clk), .rst(rst), .start(start), .out_ready(out_ready),
        .out_valid(out_valid), .dtfag_i(di), .dtfag_t(dt), .dtfag_j(dj),
        .rom_cen(rom_cen), .busy(busy), .done(done)
    );

    dtfag_idx_seq #(.RADIX_W(4), .I_MAX(1), .T_MAX(0), .J_MAX(2)) dut_s (
        .clk(clk), .rst(rst), .start(s_start), .out_ready(s_ready),
        .out_valid(s_valid), .dtfag_i(s_di), .dtfag_t(s_dt), .dtfag_j(s_dj),
        .rom_cen(s_rom_cen), .busy(s_busy), .done(s_done)
    );

    int checks = 0;
    int errors = 0;

    logic [11:0] q[$];
    logic [11:0] sq[$];
    bit exp_done = 1'b0;
    bit s_exp_done = 1'b0;
    int fire_cnt = 0, rom0_cnt = 0, done_cnt = 0;
    int s_fire_cnt = 0, s_done_cnt = 0;

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // default-instance monitor
    always @(negedge clk) begin
        if (rst) begin
            exp_done = 1'b0;
            chk({out_valid, busy, done, rom_cen, di, dt, dj} == 16'h1000, "reset_state",
                int'({out_valid, busy, done, rom_cen, di, dt, dj}), 16'h1000);
        end else begin
            if (exp_done) begin
                chk(done && !busy && !out_valid, "done_pulse", int'({done, busy, out_valid}), 3'b100);
                exp_done = 1'b0;
                done_cnt++;
            end else begin
                chk(!done, "no_spurious_done", int'(done), 0);
            end
            if (!rom_cen) rom0_cnt++;
            if (out_valid) begin
                chk(busy, "busy_in_run", int'(busy), 1);
                if (q.size() == 0) begin
                    chk(1'b0, "unexpected_tuple", int'({di, dt, dj}), 0);
                end else begin
                    chk({di, dt, dj} == q[0], "tuple", int'({di, dt, dj}), int'(q[0]));
                    if (out_ready) begin
                        chk(!rom_cen, "rom_cen_fire", int'(rom_cen), 0);
                        void'(q.pop_front());
                        fire_cnt++;
                        if (q.size() == 0) exp_done = 1'b1;
                    end else begin
                        chk(rom_cen, "rom_cen_stall", int'(rom_cen), 1);
                    end
                end
            end else begin
                chk(rom_cen, "rom_cen_idle", int'(rom_cen), 1);
            end
        end
    end

    // small-instance monitor
    always @(negedge clk) begin
        if (rst) begin
            s_exp_done = 1'b0;
        end else begin
            if (s_exp_done) begin
                chk(s_done && !s_busy && !s_valid, "s_done_pulse", int'({s_done, s_busy, s_valid}), 3'b100);
                s_exp_done = 1'b0;
                s_done_cnt++;
            end else begin
                chk(!s_done, "s_no_spurious_done", int'(s_done), 0);
            end
            if (s_valid) begin
                if (sq.size() == 0) begin
                    chk(1'b0, "s_unexpected_tuple", int'({s_di, s_dt, s_dj}), 0);
                end else begin
                    chk({s_di, s_dt, s_dj} == sq[0], "s_tuple", int'({s_di, s_dt, s_dj}), int'(sq[0]));
                    chk(s_rom_cen == !s_ready, "s_rom_cen", int'(s_rom_cen), int'(!s_ready));
                    if (s_ready) begin
                        void'(sq.pop_front());
                        s_fire_cnt++;
                        if (sq.size() == 0) s_exp_done = 1'b1;
                    end
                end
            end
        end
    end

    task automatic run_main(input bit rnd, input bit inject, input bit do_rst);
        int  stall;
        int  len;
        int  cyc;
        bit  bp_done;
        bit  sr_done;
        bit  aborted;
        stall = 0; bp_done = 1'b0; sr_done = 1'b0; aborted = 1'b0;
        @(posedge clk); #1;
        chk(!busy && !done, "idle_before_start", int'({busy, done}), 0);
        for (int i = 0; i <= 15; i++)
            for (int t = 0; t <= 15; t++)
                for (int j = J0; j <= 15; j++)
                    q.push_back({4'(i), 4'(t), 4'(j)});
        len = q.size();
        fire_cnt = 0; rom0_cnt = 0; done_cnt = 0;
        start = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk(out_valid, "start_latency", int'(out_valid), 1);
        for (cyc = 0; cyc < 30000; cyc++) begin
            if (q.size() == 0 && !exp_done) break;
            start = 1'b0;
            if (do_rst && out_valid && {di, dt, dj} == 12'h179) begin
                rst = 1'b1;
                q.delete();
                aborted = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                break;
            end
            if (inject && !bp_done && out_valid && {di, dt, dj} == 12'h005) begin
                stall = 3;
                bp_done = 1'b1;
            end
            if (inject && !sr_done && out_valid && {di, dt, dj} == 12'h234) begin
                start = 1'b1;
                sr_done = 1'b1;
            end
            if (stall > 0) begin
                out_ready = 1'b0;
                stall--;
            end else begin
                out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        if (!aborted) begin
            chk(q.size() == 0 && !exp_done, "sweep_complete", q.size(), 0);
            chk(fire_cnt == len, "fire_count", fire_cnt, len);
            chk(rom0_cnt == len, "rom_cen_low_count", rom0_cnt, len);
            chk(done_cnt == 1, "done_count", done_cnt, 1);
            chk(!busy && !out_valid, "idle_after_sweep", int'({busy, out_valid}), 0);
        end
    endtask

    task automatic run_small();
        int len;
        int cyc;
        for (int i = 0; i <= 1; i++)
            for (int j = J0; j <= 2; j++)
                sq.push_back({4'(i), 4'd0, 4'(j)});
        len = sq.size();
        s_fire_cnt = 0; s_done_cnt = 0;
        @(posedge clk); #1;
        s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        for (cyc = 0; cyc < 1000; cyc++) begin
            if (sq.size() == 0 && !s_exp_done) break;
            s_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        chk(sq.size() == 0 && !s_exp_done, "s_sweep_complete", sq.size(), 0);
        chk(s_fire_cnt == len, "s_fire_count", s_fire_cnt, len);
        chk(s_done_cnt == 1, "s_done_count", s_done_cnt, 1);
        repeat (4) @(posedge clk);
        #1;
        chk(s_done_cnt == 1 && !s_busy, "s_single_done", s_done_cnt, 1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        run_main(1'b0, 1'b1, 1'b0);
        run_main(1'b1, 1'b0, 1'b0);
        run_main(1'b1, 1'b0, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        chk(done_cnt == 0 && !busy, "no_done_after_abort", done_cnt, 0);
        run_main(1'b1, 1'b0, 1'b0);
        run_small();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
